// File: rtl/board_merge.sv
// board_merge: locks an active-piece buffer into the settled playfield,
// removes full rows (with cascade recheck), and keeps line/overflow status.
//
// Handshake: lock_req and clear_req are only sampled while busy=0 (IDLE);
// a request seen while busy=1 is dropped, not queued. An accepted lock_req
// raises busy on the next cycle and completes with a one-cycle done pulse,
// registered on the return to IDLE, together with the updated
// lines_cleared/total_lines/game_over. clear_req beats a simultaneous
// lock_req. Reset aborts a lock without producing done.
module board_merge #(
   parameter int ROWS = 22,
   parameter int COLS = 10
) (
   input  logic                       Clk,
   input  logic                       Reset_h,
   input  logic [ROWS-1:0][COLS-1:0]  piece_rows,
   input  logic                       lock_req,
   input  logic                       clear_req,
   output logic [ROWS-1:0][COLS-1:0]  board_rows,
   output logic                       busy,
   output logic                       done,
   output logic [2:0]                 lines_cleared,
   output logic [15:0]                total_lines,
   output logic                       game_over,
   output logic [1:0]                 state_dbg
);

   localparam int IDX_W = $clog2(ROWS);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_MERGE  = 2'd1,
      S_SCAN   = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   state_t                     state_q, state_d;
   logic [ROWS-1:0][COLS-1:0]  board_q, board_d;
   logic [ROWS-1:0][COLS-1:0]  snap_q, snap_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [2:0]                 cnt_q, cnt_d;
   logic                       done_q, done_d;
   logic [2:0]                 lines_q, lines_d;
   logic [15:0]                total_q, total_d;
   logic                       go_q, go_d;
   logic                       row_full;
   logic [16:0]                total_sum;

   // Next-state and datapath: one step of the lock/clear sequence per cycle.
   always_comb begin
      state_d   = state_q;
      board_d   = board_q;
      snap_d    = snap_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      lines_d   = lines_q;
      total_d   = total_q;
      go_d      = go_q;
      row_full  = &board_q[idx_q];
      total_sum = {1'b0, total_q} + 17'(cnt_q);

      case (state_q)
         S_IDLE: begin
            if (clear_req) begin
               board_d = '0;
               go_d    = 1'b0;
            end else if (lock_req) begin
               // The snapshot decouples the merge from later piece_rows edits.
               snap_d  = piece_rows;
               state_d = S_MERGE;
            end
         end
         S_MERGE: begin
            board_d = board_q | snap_q;
            idx_d   = '0;
            cnt_d   = '0;
            state_d = S_SCAN;
         end
         S_SCAN: begin
            // At most four removals per lock keeps SCAN within ROWS+4 cycles.
            if (row_full && (cnt_q < 3'd4)) begin
               for (int r = 0; r < ROWS - 1; r++) begin
                  if (r >= int'(idx_q)) begin
                     board_d[r] = board_q[r+1];
                  end
               end
               board_d[ROWS-1] = '0;
               cnt_d = (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;
               // Index is held so the row that dropped into place is rechecked.
            end else if (idx_q == IDX_W'(ROWS - 1)) begin
               state_d = S_FINISH;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_FINISH: begin
            done_d  = 1'b1;
            lines_d = cnt_q;
            total_d = total_sum[16] ? 16'hFFFF : total_sum[15:0];
            if ((|board_q[ROWS-1]) || (|board_q[ROWS-2])) begin
               go_d = 1'b1;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset empties the board and aborts any lock.
   always_ff @(posedge Clk or posedge Reset_h) begin
      if (Reset_h) begin
         state_q <= S_IDLE;
         board_q <= '0;
         snap_q  <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         lines_q <= '0;
         total_q <= '0;
         go_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         board_q <= board_d;
         snap_q  <= snap_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         lines_q <= lines_d;
         total_q <= total_d;
         go_q    <= go_d;
      end
   end

   assign board_rows    = board_q;
   assign busy          = (state_q != S_IDLE);
   assign done          = done_q;
   assign lines_cleared = lines_q;
   assign total_lines   = total_q;
   assign game_over     = go_q;
   assign state_dbg     = state_q;

endmodule
